// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer. It carries one packed payload of DATA_W bits between
// two CPU stages. Each boundary can apply backpressure on its own, so no
// global stall is needed.
//
// Timing
//   - Full throughput and 1-cycle latency.
//   - in_ready, out_valid and out_data are decoded only from registered
//     state, so there is no combinational path from out_ready to in_ready.
//
// Parameters
//   DATA_W      payload width in bits (1..1024)
//   BUBBLE_VAL  payload shown when the stage is empty; also loaded on
//               flush and reset (NOP encoding by default)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept a payload
//   in_data    in   upstream payload
//   out_valid  out  stage presents a valid payload
//   out_ready  in   downstream accepts the payload
//   out_data   out  payload to downstream (BUBBLE_VAL when not valid)
//   stall_cnt  out  count of backpressure cycles (zero unless stats enabled)
//
// Optional feature
//   Define PIPE_STAGE_ELASTIC_STATS_EN to build a saturating counter of
//   cycles with out_valid && !out_ready. Only rst clears it.
//   Without the macro, stall_cnt is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,   // main register valid
        ST_FULL  = 2'd2    // main and skid registers valid
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] main_next_s;
    logic [DATA_W-1:0] skid_next_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              in_fire_s;
    logic              out_fire_s;

    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = out_valid_s && out_ready;

    // State register; reset clears the stage at once, with no partial transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Payload registers; in_data is captured only on in_fire, so X on an idle bus never enters the stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_r <= BUBBLE_VAL;
            skid_data_r <= BUBBLE_VAL;
        end else begin
            main_data_r <= main_next_s;
            skid_data_r <= skid_next_s;
        end
    end

    // Next-state and next-payload selection; flush wins over any handshake
    always_comb begin
        state_next_s = state_r;
        main_next_s  = main_data_r;
        skid_next_s  = skid_data_r;
        if (flush) begin
            // A same-cycle in_fire is dropped. A same-cycle out_fire was
            // already seen by downstream.
            state_next_s = ST_EMPTY;
            main_next_s  = BUBBLE_VAL;
            skid_next_s  = BUBBLE_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_next_s = ST_BUSY;
                        main_next_s  = in_data;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        state_next_s = ST_BUSY;
                        main_next_s  = in_data;
                    end else if (in_fire_s) begin
                        // Downstream stalled: park the new beat in the skid slot
                        state_next_s = ST_FULL;
                        skid_next_s  = in_data;
                    end else if (out_fire_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_valid cannot fire
                    if (out_fire_s) begin
                        state_next_s = ST_BUSY;
                        main_next_s  = skid_data_r;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                    main_next_s  = BUBBLE_VAL;
                    skid_next_s  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Handshake outputs decoded purely from the registered state
    always_comb begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        case (state_r)
            ST_EMPTY: begin
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
            ST_BUSY: begin
                out_valid_s = 1'b1;
                in_ready_s  = 1'b1;
            end
            ST_FULL: begin
                out_valid_s = 1'b1;
                in_ready_s  = 1'b0;
            end
            default: begin
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
        endcase
    end

    assign out_valid = out_valid_s;
    assign in_ready  = in_ready_s;
    // Mask the main register when the stage is empty: it may still hold a
    // payload that was already delivered.
    assign out_data  = out_valid_s ? main_data_r : BUBBLE_VAL;

`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    logic [31:0] stall_cnt_r;

    // Saturating backpressure counter; only reset clears it, flush does not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid_s && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Self-checking bench for pipe_stage_elastic.
//   - dut:   default build (32-bit payload, NOP bubble).
//   - dut64: 64-bit payload with a zero bubble.
// The reference model treats the stage as a FIFO of depth two:
//   - flush empties it;
//   - out_valid means the FIFO is non-empty;
//   - in_ready means the FIFO is not full.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam logic [31:0] BUBBLE32 = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] stall_cnt;

    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [63:0] in_data64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_data64;
    logic [31:0] stall_cnt64;

    int tests;
    int fails;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] delivered[$];
    logic [31:0] stall_m;

    pipe_stage_elastic dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_elastic #(
        .DATA_W     (64),
        .BUBBLE_VAL (64'd0)
    ) dut64 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush64),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_data   (in_data64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_data  (out_data64),
        .stall_cnt (stall_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : BUBBLE32;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
        chk({tag, ".out_data"},  64'(out_data),  64'(exp_data));
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
`else
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    // One clock cycle: drive, check the outputs, let the edge happen, then advance the model
    task automatic cycle(input string tag, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl);
        logic ifire;
        logic ofire;
        logic vld;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        check_outputs(tag);
        vld   = (mq.size() > 0);
        ifire = iv && (mq.size() < 2);
        ofire = vld && ordy;
        if (ofire) delivered.push_back(out_data);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(d);
        end
        if (vld && !ordy && (stall_m != 32'hFFFF_FFFF)) stall_m = stall_m + 32'd1;
    endtask

    // Assert reset away from the clock edge with in_valid high, and check the immediate effect
    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = $urandom;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ".rst_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".rst_out_data"},  64'(out_data),  64'(BUBBLE32));
        chk({tag, ".rst_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".rst_stall_cnt"}, 64'(stall_cnt), 64'd0);
        mq.delete();
        stall_m = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] prev64;
        tests      = 0;
        fails      = 0;
        stall_m    = 32'd0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        out_ready  = 1'b0;
        flush64    = 1'b0;
        in_valid64 = 1'b0;
        in_data64  = 64'd0;
        out_ready64 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.out_data",  64'(out_data),  64'(BUBBLE32));
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming: 1..8 back to back with out_ready high
        delivered.delete();
        for (int i = 1; i <= 8; i++) cycle("stream", 1'b1, 32'(i), 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("stream.order", 64'((i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF), 64'(i + 1));

        // Backpressure: A then B fill the stage, C waits upstream, then drain in order
        delivered.delete();
        cycle("bp", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("bp", 1'b1, 32'hB, 1'b0, 1'b0);
        cycle("bp_full", 1'b1, 32'hC, 1'b0, 1'b0);
        chk("bp.in_ready_low", 64'(in_ready), 64'd0);
        chk("bp.holds_A",      64'(out_data), 64'hA);
        cycle("bp_drain", 1'b1, 32'hC, 1'b1, 1'b0);
        cycle("bp_drain", 1'b1, 32'hC, 1'b1, 1'b0);
        cycle("bp_drain", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("bp_drain", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp.count", 64'(delivered.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk("bp.order", 64'((i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF), 64'(32'hA + i));

        // Flush while FULL with a same-cycle upstream offer
        cycle("fl", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("fl", 1'b1, 32'hB, 1'b0, 1'b0);
        cycle("fl_kill", 1'b1, 32'hC, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.out_data",  64'(out_data),  64'(BUBBLE32));
        for (int i = 0; i < 3; i++) cycle("fl_after", 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of traffic with the stage FULL
        cycle("rstf", 1'b1, 32'h11, 1'b0, 1'b0);
        cycle("rstf", 1'b1, 32'h22, 1'b0, 1'b0);
        do_reset("rst_full");
        for (int i = 0; i < 3; i++) cycle("rst_after", 1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure counter
        cycle("stall_load", 1'b1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("stall", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
        chk("stall.five", 64'(stall_cnt), 64'd5);
        dut.stall_cnt_r = 32'hFFFF_FFFD;
        stall_m = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) cycle("stall_sat", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall.saturate", 64'(stall_cnt), 64'hFFFF_FFFF);
`else
        chk("stall.tied_zero", 64'(stall_cnt), 64'd0);
`endif
        cycle("stall_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // 64-bit stage, one transfer per cycle for 16 cycles
        @(negedge clk);
        chk("w64.idle_valid", 64'(out_valid64), 64'd0);
        chk("w64.idle_data",  out_data64,       64'd0);
        prev64 = 64'd0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("w64.valid", 64'(out_valid64), 64'd1);
                chk("w64.ready", 64'(in_ready64),  64'd1);
                chk("w64.data",  out_data64,       prev64);
            end
            in_valid64  = (k < 16);
            prev64      = {$urandom, $urandom};
            in_data64   = prev64;
            out_ready64 = 1'b1;
        end
        @(negedge clk);
        chk("w64.empty", 64'(out_valid64), 64'd0);

        // Random traffic against the FIFO model
        for (int i = 0; i < 400; i++)
            cycle("rand", ($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
